// File: rtl/core_sequencer.sv
// Instruction-cycle sequencer: fetch/decode/execute/memory/writeback with request timeout.
// Define CORE_SEQUENCER_TRAP_EN to make SYSTEM halt and ILLEGAL fault; otherwise both retire like FENCE.
//
// state     | meaning
// FETCH     | request instruction word, load IR on mem_ready
// DECODE    | capture instruction class
// EXECUTE   | resolve class: branch/fence retire here, others move on
// MEMORY    | hold load/store request until mem_ready
// WRITEBACK | write rd and advance PC (target for JAL/JALR)
// HALT      | terminal, halted asserted
// FAULT     | terminal, fault asserted (timeout or illegal)
module core_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run_enable,
  input  logic [2:0]  instr_class,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        fetch_req,
  output logic        ir_load,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic        rd_write_enable,
  output logic        pc_load,
  output logic        pc_sel,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5,
    FAULT     = 3'd6
  } seqState_t;

  localparam logic [2:0] CLS_ALU     = 3'd0;
  localparam logic [2:0] CLS_LOAD    = 3'd1;
  localparam logic [2:0] CLS_STORE   = 3'd2;
  localparam logic [2:0] CLS_BRANCH  = 3'd3;
  localparam logic [2:0] CLS_JUMP    = 3'd4;
  localparam logic [2:0] CLS_SYSTEM  = 3'd5;
  localparam logic [2:0] CLS_FENCE   = 3'd6;
  localparam logic [2:0] CLS_ILLEGAL = 3'd7;

  localparam logic [7:0] TOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  seqState_t  curState;
  seqState_t  nxtState;
  logic [2:0] classQ;
  logic [7:0] toutCnt;
  logic       reqActive;
  logic       toutHit;
  logic       fetchReq;
  logic       irLoad;
  logic       memRdReq;
  logic       memWrReq;
  logic       rdWe;
  logic       pcLoad;
  logic       pcSel;
  logic       haltedInt;
  logic       faultInt;

  // Request activity derived from state only, so the timeout path has no loop through the output decode.
  assign reqActive = ((curState == FETCH) && run_enable) || (curState == MEMORY);
  assign toutHit   = reqActive && run_enable && !mem_ready && (toutCnt == TOUT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      curState <= FETCH;
    end else begin
      curState <= nxtState;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      classQ <= CLS_ALU;
    end else if (curState == DECODE) begin
      classQ <= instr_class;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      toutCnt <= 8'd0;
    end else if ((curState != FETCH) && (curState != MEMORY)) begin
      toutCnt <= 8'd0;
    end else if (reqActive && mem_ready) begin
      toutCnt <= 8'd0;
    end else if (reqActive && run_enable && (toutCnt != TOUT_LAST)) begin
      toutCnt <= toutCnt + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instret <= 32'd0;
    end else if (pcLoad) begin
      instret <= instret + 32'd1;
    end
  end

  always_comb begin
    nxtState  = curState;
    fetchReq  = 1'b0;
    irLoad    = 1'b0;
    memRdReq  = 1'b0;
    memWrReq  = 1'b0;
    rdWe      = 1'b0;
    pcLoad    = 1'b0;
    pcSel     = 1'b0;
    haltedInt = 1'b0;
    faultInt  = 1'b0;
    case (curState)
      FETCH: begin
        fetchReq = run_enable;
        if (run_enable && mem_ready) begin
          irLoad   = 1'b1;
          nxtState = DECODE;
        end else if (toutHit) begin
          nxtState = FAULT;
        end
      end
      DECODE: begin
        nxtState = EXECUTE;
      end
      EXECUTE: begin
        case (classQ)
          CLS_ALU, CLS_JUMP: begin
            nxtState = WRITEBACK;
          end
          CLS_LOAD, CLS_STORE: begin
            nxtState = MEMORY;
          end
          CLS_BRANCH: begin
            pcLoad   = 1'b1;
            pcSel    = branch_taken;
            nxtState = FETCH;
          end
          CLS_FENCE: begin
            pcLoad   = 1'b1;
            nxtState = FETCH;
          end
`ifdef CORE_SEQUENCER_TRAP_EN
          CLS_SYSTEM: begin
            nxtState = HALT;
          end
          CLS_ILLEGAL: begin
            nxtState = FAULT;
          end
`else
          CLS_SYSTEM, CLS_ILLEGAL: begin
            pcLoad   = 1'b1;
            nxtState = FETCH;
          end
`endif
          default: begin
            nxtState = FAULT;
          end
        endcase
      end
      MEMORY: begin
        if (classQ == CLS_LOAD) begin
          memRdReq = 1'b1;
        end else begin
          memWrReq = 1'b1;
        end
        // Completion beats a timeout expiring in the same cycle.
        if (mem_ready) begin
          if (classQ == CLS_LOAD) begin
            nxtState = WRITEBACK;
          end else begin
            pcLoad   = 1'b1;
            nxtState = FETCH;
          end
        end else if (toutHit) begin
          nxtState = FAULT;
        end
      end
      WRITEBACK: begin
        rdWe     = 1'b1;
        pcLoad   = 1'b1;
        pcSel    = (classQ == CLS_JUMP);
        nxtState = FETCH;
      end
      HALT: begin
`ifdef CORE_SEQUENCER_TRAP_EN
        haltedInt = 1'b1;
`endif
        nxtState  = HALT;
      end
      FAULT: begin
        faultInt = 1'b1;
        nxtState = FAULT;
      end
      default: begin
        nxtState = FAULT;
      end
    endcase
  end

  // Fetch-side outputs are combinational on run_enable/mem_ready, so keep them quiet while reset is held.
  assign fetch_req       = fetchReq && !reset;
  assign ir_load         = irLoad && !reset;
  assign mem_rd_req      = memRdReq;
  assign mem_wr_req      = memWrReq;
  assign rd_write_enable = rdWe;
  assign pc_load         = pcLoad;
  assign pc_sel          = pcSel;
  assign halted          = haltedInt;
  assign fault           = faultInt;
  assign state           = curState;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer with TIMEOUT_CYCLES=4.
// Trap-dependent checks follow CORE_SEQUENCER_TRAP_EN as defined for the build.
module tb_core_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        run_enable;
  logic [2:0]  instr_class;
  logic        branch_taken;
  logic        mem_ready;
  logic        fetch_req;
  logic        ir_load;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic        rd_write_enable;
  logic        pc_load;
  logic        pc_sel;
  logic        halted;
  logic        fault;
  logic [2:0]  state;
  logic [31:0] instret;

  int nCompared   = 0;
  int nMismatched = 0;
  int reqCycles;
  logic [31:0] expInstret;

  core_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .run_enable      (run_enable),
    .instr_class     (instr_class),
    .branch_taken    (branch_taken),
    .mem_ready       (mem_ready),
    .fetch_req       (fetch_req),
    .ir_load         (ir_load),
    .mem_rd_req      (mem_rd_req),
    .mem_wr_req      (mem_wr_req),
    .rd_write_enable (rd_write_enable),
    .pc_load         (pc_load),
    .pc_sel          (pc_sel),
    .halted          (halted),
    .fault           (fault),
    .state           (state),
    .instret         (instret)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    expInstret = 32'd0;
  endtask

  // From FETCH: fetch immediately, present cls in DECODE, return positioned in EXECUTE.
  task automatic toExecute(input logic [2:0] cls);
    run_enable  = 1'b1;
    mem_ready   = 1'b1;
    instr_class = cls;
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, wanted finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    run_enable   = 1'b1;
    instr_class  = 3'd0;
    branch_taken = 1'b0;
    mem_ready    = 1'b0;
    expInstret   = 32'd0;
    #12;
    checkVal("rst_state", state, 0);
    checkVal("rst_fetch_req", fetch_req, 0);
    checkVal("rst_instret", instret, 0);
    mem_ready = 1'b1;
    #1;
    checkVal("rst_ir_load", ir_load, 0);
    @(negedge clock);
    reset      = 1'b0;
    mem_ready  = 1'b0;
    run_enable = 1'b0;
    #1;
    checkVal("idle_fetch_req", fetch_req, 0);

    // ALU: 0,1,2,4,0
    run_enable  = 1'b1;
    mem_ready   = 1'b1;
    instr_class = 3'd0;
    #1;
    checkVal("alu_f_state", state, 0);
    checkVal("alu_f_fetch_req", fetch_req, 1);
    checkVal("alu_f_ir_load", ir_load, 1);
    tick();
    checkVal("alu_d_state", state, 1);
    checkVal("alu_d_fetch_req", fetch_req, 0);
    checkVal("alu_d_ir_load", ir_load, 0);
    tick();
    mem_ready = 1'b0;
    #1;
    checkVal("alu_e_state", state, 2);
    checkVal("alu_e_rdwe", rd_write_enable, 0);
    checkVal("alu_e_pcload", pc_load, 0);
    tick();
    checkVal("alu_w_state", state, 4);
    checkVal("alu_w_rdwe", rd_write_enable, 1);
    checkVal("alu_w_pcload", pc_load, 1);
    checkVal("alu_w_pcsel", pc_sel, 0);
    tick();
    expInstret = 32'd1;
    checkVal("alu_end_state", state, 0);
    checkVal("alu_instret", instret, expInstret);

    // LOAD: mem_ready after 3 wait cycles
    toExecute(3'd1);
    checkVal("ld_e_state", state, 2);
    tick();
    reqCycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (state != 3'd3) break;
      mem_ready = (i == 3);
      #1;
      if (mem_rd_req) reqCycles++;
      checkVal("ld_no_wr", mem_wr_req, 0);
      tick();
    end
    mem_ready = 1'b0;
    checkVal("ld_rd_cycles", reqCycles, 4);
    checkVal("ld_wb_state", state, 4);
    checkVal("ld_no_fault", fault, 0);
    tick();
    expInstret = 32'd2;
    checkVal("ld_instret", instret, expInstret);

    // JAL: writeback selects target
    toExecute(3'd4);
    tick();
    checkVal("jal_w_pcsel", pc_sel, 1);
    checkVal("jal_w_rdwe", rd_write_enable, 1);
    tick();
    expInstret = 32'd3;
    checkVal("jal_instret", instret, expInstret);

    // Branch taken / not taken
    toExecute(3'd3);
    branch_taken = 1'b1;
    #1;
    checkVal("br_t_pcload", pc_load, 1);
    checkVal("br_t_pcsel", pc_sel, 1);
    checkVal("br_t_rdwe", rd_write_enable, 0);
    tick();
    expInstret = 32'd4;
    checkVal("br_t_state", state, 0);
    checkVal("br_t_rdwe_after", rd_write_enable, 0);
    toExecute(3'd3);
    branch_taken = 1'b0;
    #1;
    checkVal("br_n_pcload", pc_load, 1);
    checkVal("br_n_pcsel", pc_sel, 0);
    tick();
    expInstret = 32'd5;
    checkVal("br_n_instret", instret, expInstret);

    // STORE: mem_ready lands exactly on the expiry cycle
    toExecute(3'd2);
    tick();
    reqCycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (state != 3'd3) break;
      mem_ready = (i == 3);
      #1;
      if (mem_wr_req) reqCycles++;
      if (i == 3) checkVal("st_last_pcload", pc_load, 1);
      tick();
    end
    mem_ready = 1'b0;
    expInstret = 32'd6;
    checkVal("st_wr_cycles", reqCycles, 4);
    checkVal("st_state", state, 0);
    checkVal("st_fault", fault, 0);
    checkVal("st_instret", instret, expInstret);

    // SYSTEM class
    toExecute(3'd5);
`ifdef CORE_SEQUENCER_TRAP_EN
    checkVal("sys_e_pcload", pc_load, 0);
    tick();
    checkVal("sys_state", state, 5);
    checkVal("sys_halted", halted, 1);
    checkVal("sys_fetch_req", fetch_req, 0);
    checkVal("sys_instret", instret, expInstret);
    tick();
    checkVal("sys_still_halt", state, 5);
    doReset();
    toExecute(3'd7);
    checkVal("ill_e_pcload", pc_load, 0);
    tick();
    checkVal("ill_state", state, 6);
    checkVal("ill_fault", fault, 1);
    doReset();
`else
    checkVal("sys_e_pcload", pc_load, 1);
    checkVal("sys_e_pcsel", pc_sel, 0);
    tick();
    expInstret = expInstret + 32'd1;
    checkVal("sys_state", state, 0);
    checkVal("sys_halted", halted, 0);
    checkVal("sys_instret", instret, expInstret);
`endif

    // STORE with no mem_ready: faults after 4 request cycles
    toExecute(3'd2);
    tick();
    reqCycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (state != 3'd3) break;
      #1;
      if (mem_wr_req) reqCycles++;
      tick();
    end
    checkVal("sto_wr_cycles", reqCycles, 4);
    checkVal("sto_state", state, 6);
    checkVal("sto_fault", fault, 1);
    checkVal("sto_wr_req", mem_wr_req, 0);
    checkVal("sto_fetch_req", fetch_req, 0);
    checkVal("sto_instret", instret, expInstret);

    // Fetch timeout with run_enable pausing the counter mid-way
    doReset();
    run_enable = 1'b1;
    mem_ready  = 1'b0;
    reqCycles  = 0;
    for (int i = 0; i < 12; i++) begin
      if (state != 3'd0) break;
      run_enable = !(i >= 2 && i < 7);
      #1;
      if (fetch_req) reqCycles++;
      tick();
    end
    checkVal("fto_req_cycles", reqCycles, 4);
    checkVal("fto_state", state, 6);
    checkVal("fto_fault", fault, 1);

    // Reset in the middle of a store
    doReset();
    toExecute(3'd0);
    tick();
    tick();
    expInstret = 32'd1;
    checkVal("rm_pre_instret", instret, expInstret);
    toExecute(3'd2);
    tick();
    #1;
    checkVal("rm_wr_before", mem_wr_req, 1);
    reset = 1'b1;
    #1;
    checkVal("rm_wr_after", mem_wr_req, 0);
    checkVal("rm_state", state, 0);
    checkVal("rm_instret", instret, 0);
    checkVal("rm_pcload", pc_load, 0);
    checkVal("rm_rdwe", rd_write_enable, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkVal("rm_post_fetch_req", fetch_req, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
